// File: rtl/ram_fifo_if.sv
// Bundle of the FIFO producer/consumer handshake and the dual_port_ram port A/B wiring.
// The slave modport is the controller's view; master is the environment (producer, consumer, RAM).
interface ram_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_in_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_in_b;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] data_out_b;

  modport slave (
    input  wr_en, wr_data, rd_en, data_out_b,
    output rd_data, rd_valid, full, empty, count, overflow, underflow,
           addr_a, data_in_a, we_a, addr_b, data_in_b, we_b
  );

  modport master (
    output wr_en, wr_data, rd_en, data_out_b,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow,
           addr_a, data_in_a, we_a, addr_b, data_in_b, we_b
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external dual_port_ram: port A writes, port B reads with
// one cycle of registered latency, so rd_valid trails the accepted pop by one cycle.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  ram_fifo_if.slave      bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_valid;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  push_ok;
  logic                  pop_ok;

  // Flags come from registered count only, so a same-cycle pop never frees room for a push.
  assign full    = (count == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = bus.wr_en & ~full;
  assign pop_ok  = bus.rd_en & ~empty;

  assign bus.addr_a    = wr_ptr;
  assign bus.data_in_a = bus.wr_data;
  assign bus.we_a      = push_ok;
  assign bus.addr_b    = rd_ptr;
  assign bus.data_in_b = '0;
  assign bus.we_b      = 1'b0;

  assign bus.rd_data   = bus.data_out_b;
  assign bus.rd_valid  = rd_valid;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values;
  // the word storage lives in the external RAM and is deliberately left out of the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Pointers are exactly ADDR_WIDTH bits wide, so the increment wraps modulo DEPTH.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid  <= pop_ok;
      overflow  <= bus.wr_en & full;
      underflow <= bus.rd_en & empty;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural dual_port_ram and a queue-based FIFO model.
module tb_ram_fifo_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;

  ram_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural RAM: synchronous write on A, registered read on B (read-old on collision).
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.we_a) mem[bus.addr_a] <= bus.data_in_a;
    bus.data_out_b <= mem[bus.addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: contents as a queue, addresses as push/pop counts modulo DEPTH.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_data_q[$];
  int  wr_addr = 0;
  int  rd_addr = 0;
  bit  exp_valid = 1'b0;
  bit  exp_ovf   = 1'b0;
  bit  exp_udf   = 1'b0;
  logic [DW-1:0] exp_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: check flags at the negedge, drive, check port A/B wiring, advance the model.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r);
    bit full_m, empty_m, push_ok, pop_ok;
    @(negedge clk);
    check("count", 32'(bus.count), 32'(model_q.size()));
    check("full",  32'(bus.full),  32'(model_q.size() == DEPTH));
    check("empty", 32'(bus.empty), 32'(model_q.size() == 0));
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    push_ok = w && !full_m;
    pop_ok  = r && !empty_m;
    #1;
    check("we_a",   32'(bus.we_a),   32'(push_ok));
    check("addr_a", 32'(bus.addr_a), 32'(wr_addr));
    check("addr_b", 32'(bus.addr_b), 32'(rd_addr));
    check("we_b",   32'(bus.we_b),   32'd0);
    if (push_ok) check("data_in_a", 32'(bus.data_in_a), 32'(d));
    exp_valid = pop_ok;
    exp_ovf   = w && full_m;
    exp_udf   = r && empty_m;
    if (pop_ok) begin
      exp_data_q.push_back(model_q.pop_front());
      rd_addr = (rd_addr + 1) % DEPTH;
    end
    if (push_ok) begin
      model_q.push_back(d);
      wr_addr = (wr_addr + 1) % DEPTH;
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    cycle(1'b1, d, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0);
  endtask

  // Monitor: compares registered outputs against what the stimulus predicted for this edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        check("rd_valid",  32'(bus.rd_valid),  32'(exp_valid));
        check("overflow",  32'(bus.overflow),  32'(exp_ovf));
        check("underflow", 32'(bus.underflow), 32'(exp_udf));
        if (bus.rd_valid === 1'b1) begin
          if (exp_data_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_data: got unexpected word %0h, expected none at %0t", bus.rd_data, $time);
          end else begin
            exp_word = exp_data_q.pop_front();
            check("rd_data", 32'(bus.rd_data), 32'(exp_word));
          end
        end
      end
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end
  end

  task automatic check_reset_state();
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_empty",     32'(bus.empty),     32'd1);
    check("rst_full",      32'(bus.full),      32'd0);
    check("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    check("rst_we_a",      32'(bus.we_a),      32'd0);
    check("rst_addr_a",    32'(bus.addr_a),    32'd0);
    check("rst_addr_b",    32'(bus.addr_b),    32'd0);
  endtask

  // Accept a pop, then assert reset asynchronously just after that edge.
  task automatic mid_reset();
    pop();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_q.delete();
    exp_data_q.delete();
    wr_addr   = 0;
    rd_addr   = 0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    #2;
    check_reset_state();
    @(negedge clk);
    bus.rd_en = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    // Three words in, three out.
    push(8'hA1); push(8'hB2); push(8'hC3);
    pop(); pop(); pop();
    idle();

    // Pop on empty.
    pop();
    idle();

    // Fill to full, one rejected push, then drain to verify contents.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    push(8'hEE);
    idle();
    for (int i = 0; i < DEPTH; i++) pop();
    idle();

    // Wrap-around: 10 in, 10 out, 10 more across the 15 -> 0 boundary.
    for (int i = 0; i < 10; i++) push(8'(8'h20 + i));
    for (int i = 0; i < 10; i++) pop();
    for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
    for (int i = 0; i < 10; i++) pop();
    idle();

    // Simultaneous push/pop at full, then at empty.
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    cycle(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    cycle(1'b1, 8'h66, 1'b1);
    cycle(1'b1, 8'h67, 1'b1);
    pop();
    idle();

    // Randomised traffic with epochs biased towards filling and draining.
    for (int e = 0; e < 6; e++) begin
      int pw, pr;
      pw = (e % 2 == 0) ? 80 : 25;
      pr = (e % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 100; i++)
        cycle($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
    end
    while (model_q.size() > 0) pop();
    idle();

    // Reset with five words stored and a pop in flight.
    for (int i = 0; i < 5; i++) push(8'(8'h90 + i));
    mid_reset();
    push(8'h77);
    pop();
    idle(); idle();

    check("scoreboard_drained", 32'(exp_data_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
